// File: rtl/alu_wb_buffer_pkg.sv
// Shared types for the ALU writeback buffer: widths, the buffered entry layout,
// the occupancy classification and a minimal core configuration record.
package alu_wb_buffer_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned TRANS_ID_BITS = 3;

    // Core configuration; only the datapath width is consumed here.
    typedef struct packed {
        int unsigned xlen;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{xlen: XLEN};

    // One buffered ALU result as seen by writeback.
    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [XLEN-1:0]          result;
        logic                     branch_res;
    } alu_wb_entry_t;

    // Occupancy is a pure function of the count; no state register holds it.
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;

    function automatic occ_e occ_of(input int unsigned cnt, input int unsigned depth);
        if (cnt == 0)
            return OCC_EMPTY;
        else if (cnt >= depth)
            return OCC_FULL;
        else
            return OCC_PARTIAL;
    endfunction

endpackage

// File: rtl/alu_wb_buffer.sv
// In-order result buffer between the integer ALU and the writeback port.
// Holds up to DEPTH results, back-pressures issue when full and drops all
// held results on flush. Outputs come straight from registered storage, so
// there is no combinational path from writeback ready to ALU ready.
module alu_wb_buffer
    import alu_wb_buffer_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      alu_valid_i,
    output logic                      alu_ready_o,
    input  logic [TRANS_ID_BITS-1:0]  trans_id_i,
    input  logic [CVA6Cfg.xlen-1:0]   alu_result_i,
    input  logic                      alu_branch_res_i,
    output logic                      wb_valid_o,
    input  logic                      wb_ready_i,
    output logic [TRANS_ID_BITS-1:0]  wb_trans_id_o,
    output logic [CVA6Cfg.xlen-1:0]   wb_result_o,
    output logic                      wb_branch_res_o,
    output logic                      full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    alu_wb_entry_t      mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   cnt;
    occ_e               occ;
    logic               push;
    logic               pop;
    alu_wb_entry_t      push_entry;
    alu_wb_entry_t      head_entry;

    assign occ = occ_of(32'(cnt), DEPTH);

    // Handshakes depend only on registered occupancy; flush suppresses both.
    always_comb begin
        alu_ready_o = (occ != OCC_FULL);
        wb_valid_o  = (occ != OCC_EMPTY);
        full_o      = (occ == OCC_FULL);
        push        = alu_valid_i & alu_ready_o & ~flush_i;
        pop         = wb_valid_o & wb_ready_i & ~flush_i;
    end

    assign push_entry = '{trans_id: trans_id_i, result: alu_result_i, branch_res: alu_branch_res_i};

    // Head is read from storage even when empty, so stale (never X) data shows.
    always_comb begin
        head_entry      = mem[rd_ptr];
        wb_trans_id_o   = head_entry.trans_id;
        wb_result_o     = head_entry.result;
        wb_branch_res_o = head_entry.branch_res;
    end

    // Pointer, count and storage update; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            mem    <= '{default: '0};
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed bench for alu_wb_buffer with DEPTH=2.
module tb_alu_wb_buffer;
    import alu_wb_buffer_pkg::*;

    logic                     clk;
    logic                     rst;
    logic                     flush;
    logic                     alu_valid;
    logic                     alu_ready;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          alu_result;
    logic                     alu_branch_res;
    logic                     wb_valid;
    logic                     wb_ready;
    logic [TRANS_ID_BITS-1:0] wb_trans_id;
    logic [XLEN-1:0]          wb_result;
    logic                     wb_branch_res;
    logic                     full;

    int checks   = 0;
    int failures = 0;
    logic allow_full_push = 1'b0;

    alu_wb_buffer #(.CVA6Cfg(cva6_cfg_empty), .DEPTH(2)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .alu_valid_i      (alu_valid),
        .alu_ready_o      (alu_ready),
        .trans_id_i       (trans_id),
        .alu_result_i     (alu_result),
        .alu_branch_res_i (alu_branch_res),
        .wb_valid_o       (wb_valid),
        .wb_ready_i       (wb_ready),
        .wb_trans_id_o    (wb_trans_id),
        .wb_result_o      (wb_result),
        .wb_branch_res_o  (wb_branch_res),
        .full_o           (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Issue must never present a result while the buffer is full, except
    // where the bench deliberately probes that case.
    always @(negedge clk) begin
        if (!rst && !allow_full_push)
            assert (!(alu_valid && !alu_ready)) else chk("issue_protocol", 64'd1, 64'd0);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [TRANS_ID_BITS-1:0] id,
                         input logic [XLEN-1:0] r, input logic b);
        alu_valid      = v;
        trans_id       = id;
        alu_result     = r;
        alu_branch_res = b;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wb_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        cyc();
        rst = 1'b0;

        // Reset then idle
        for (int i = 0; i < 5; i++) begin
            chk("idle_valid", wb_valid, 0);
            chk("idle_ready", alu_ready, 1);
            chk("idle_result", wb_result, 0);
            cyc();
        end
        chk("idle_full", full, 0);
        chk("idle_id", wb_trans_id, 0);
        chk("idle_branch", wb_branch_res, 0);

        // Single push with writeback ready
        wb_ready = 1'b1;
        drive(1'b1, 3'd3, 32'hDEAD_BEEF, 1'b1);
        cyc();
        drive(1'b0, '0, '0, 1'b0);
        chk("single_valid", wb_valid, 1);
        chk("single_id", wb_trans_id, 3);
        chk("single_result", wb_result, 64'hDEAD_BEEF);
        chk("single_branch", wb_branch_res, 1);
        cyc();
        chk("single_drained", wb_valid, 0);

        // Fill with back-pressure
        wb_ready = 1'b0;
        drive(1'b1, 3'd1, 32'h0000_0011, 1'b0);
        cyc();
        chk("fill1_ready", alu_ready, 1);
        chk("fill1_head", wb_trans_id, 1);
        drive(1'b1, 3'd2, 32'h0000_0022, 1'b1);
        cyc();
        drive(1'b0, '0, '0, 1'b0);
        chk("fill2_ready", alu_ready, 0);
        chk("fill2_full", full, 1);
        chk("fill2_head", wb_trans_id, 1);
        allow_full_push = 1'b1;
        drive(1'b1, 3'd7, 32'h0000_0077, 1'b1);
        cyc();
        drive(1'b0, '0, '0, 1'b0);
        allow_full_push = 1'b0;
        chk("ignored_full", full, 1);
        chk("ignored_head_id", wb_trans_id, 1);
        chk("ignored_head_res", wb_result, 64'h11);
        chk("ignored_head_br", wb_branch_res, 0);
        wb_ready = 1'b1;
        chk("drain_first_id", wb_trans_id, 1);
        cyc();
        chk("drain_second_valid", wb_valid, 1);
        chk("drain_second_id", wb_trans_id, 2);
        chk("drain_second_res", wb_result, 64'h22);
        chk("drain_ready_back", alu_ready, 1);
        chk("drain_not_full", full, 0);
        cyc();
        chk("drain_empty", wb_valid, 0);

        // Streaming: back-to-back push/pop across pointer wraps
        wb_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 3'(i), 32'h1000 + 32'(i), 1'(i));
            cyc();
            chk("stream_valid", wb_valid, 1);
            chk("stream_id", wb_trans_id, 64'(i % 8));
            chk("stream_result", wb_result, 64'h1000 + 64'(i));
            chk("stream_branch", wb_branch_res, 64'(i % 2));
            chk("stream_ready", alu_ready, 1);
        end
        drive(1'b0, '0, '0, 1'b0);
        cyc();
        chk("stream_drained", wb_valid, 0);

        // Flush with two entries held plus push and ready in the flush cycle
        wb_ready = 1'b0;
        drive(1'b1, 3'd4, 32'h0000_000A, 1'b0);
        cyc();
        drive(1'b1, 3'd5, 32'h0000_000B, 1'b0);
        cyc();
        chk("preflush_full", full, 1);
        allow_full_push = 1'b1;
        flush = 1'b1; wb_ready = 1'b1;
        drive(1'b1, 3'd6, 32'h0000_0BAD, 1'b1);
        cyc();
        allow_full_push = 1'b0;
        flush = 1'b0; wb_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        chk("flush_valid", wb_valid, 0);
        chk("flush_ready", alu_ready, 1);
        chk("flush_full", full, 0);
        cyc();
        chk("flush_stays_empty", wb_valid, 0);

        // Flush suppresses an accepted push
        drive(1'b1, 3'd6, 32'h0000_0066, 1'b0);
        cyc();
        flush = 1'b1; wb_ready = 1'b1;
        drive(1'b1, 3'd2, 32'h0000_0BAD, 1'b1);
        cyc();
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        chk("flush_push_gone", wb_valid, 0);
        cyc();
        chk("flush_push_never", wb_valid, 0);

        // Mid-stream reset while full
        wb_ready = 1'b0;
        drive(1'b1, 3'd1, 32'h0000_0111, 1'b1);
        cyc();
        drive(1'b1, 3'd2, 32'h0000_0222, 1'b1);
        cyc();
        drive(1'b0, '0, '0, 1'b0);
        chk("prereset_full", full, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_valid", wb_valid, 0);
        chk("rst_ready", alu_ready, 1);
        chk("rst_full", full, 0);
        chk("rst_result", wb_result, 0);
        chk("rst_id", wb_trans_id, 0);
        chk("rst_branch", wb_branch_res, 0);
        wb_ready = 1'b1;
        drive(1'b1, 3'd5, 32'h0000_5555, 1'b0);
        cyc();
        drive(1'b0, '0, '0, 1'b0);
        chk("post_rst_valid", wb_valid, 1);
        chk("post_rst_id", wb_trans_id, 5);
        chk("post_rst_result", wb_result, 64'h5555);
        cyc();
        chk("post_rst_drained", wb_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
